// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the circular-buffer FIFO.
package fifo_pkg;

   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_DATA_WIDTH = 8;

   // Pointer width: pointers index the array and wrap naturally.
   function automatic int PTR_W(input int depth);
      return $clog2(depth);
   endfunction

   // Occupancy counter needs one extra bit to represent "full".
   function automatic int CNT_W(input int depth);
      return PTR_W(depth) + 1;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, registered read with
// read enable. The array itself is never reset; only the read register is.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int WIDTH = DEF_DATA_WIDTH,
   localparam int AW   = PTR_W(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Write port: store the word at the write address.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port: register the addressed word; hold it when not reading.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule : fifo_ram

// File: rtl/fifo_ring.sv
// Circular-buffer FIFO: pointer/count bookkeeping, level flags, flush and
// sticky error flags around a dual-port array.
module fifo_ring
   import fifo_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int AF_LEVEL   = FIFO_DEPTH - 1,
   parameter int AE_LEVEL   = 1,
   localparam int PW        = PTR_W(FIFO_DEPTH),
   localparam int CW        = CNT_W(FIFO_DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_flush,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic                  o_wr_ready,
   input  logic                  i_rd_en,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_rd_val,
   output logic [CW-1:0]         o_count,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_rd_val;
   logic          r_overflow;
   logic          r_underflow;

   logic          w_normal;
   logic          w_empty;
   logic          w_full;
   logic          w_rd_acc;
   logic          w_wr_acc;

   // Handshake decode; flush and reset suppress all accesses.
   always_comb begin
      w_normal = !i_reset && !i_flush;
      w_empty  = (r_count == '0);
      w_full   = (r_count == DEPTH_C);
      w_rd_acc = w_normal && i_rd_en && !w_empty;
      // A full FIFO still takes a write when a read frees a slot this cycle.
      w_wr_acc = w_normal && i_wr_en && (!w_full || w_rd_acc);
   end

   // Pointers, occupancy, read-valid qualifier and sticky error flags.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rd_val    <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_rd_val <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + CW'(1);
         end else if (w_rd_acc && !w_wr_acc) begin
            r_count <= r_count - CW'(1);
         end
         r_rd_val <= w_rd_acc;
         if (i_wr_en && !w_wr_acc) begin
            r_overflow <= 1'b1;
         end
         if (i_rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   fifo_ram #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_wr_data),
      .i_re    (w_rd_acc),
      .i_raddr (r_rd_ptr),
      .o_rdata (o_rd_data)
   );

   // Level flags depend on the stored count only, never on this cycle's requests.
   always_comb begin
      o_wr_ready     = (r_count < DEPTH_C);
      o_almost_full  = (r_count >= AF_C);
      o_almost_empty = (r_count <= AE_C);
   end

   assign o_count     = r_count;
   assign o_rd_val    = r_rd_val;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule : fifo_ring

// File: tb/tb_fifo_ring.sv
// Directed bench for fifo_ring (depth 8, width 8, AF 7, AE 1).
module tb_fifo_ring;

   localparam int DEPTH = 8;
   localparam int DW    = 8;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          reset, flush, wr_en, rd_en;
   logic [DW-1:0] wr_data;
   logic          wr_ready, rd_val, almost_full, almost_empty, overflow, underflow;
   logic [DW-1:0] rd_data;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_ring #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_flush        (flush),
      .i_wr_en        (wr_en),
      .i_wr_data      (wr_data),
      .o_wr_ready     (wr_ready),
      .i_rd_en        (rd_en),
      .o_rd_data      (rd_data),
      .o_rd_val       (rd_val),
      .o_count        (count),
      .o_almost_full  (almost_full),
      .o_almost_empty (almost_empty),
      .o_overflow     (overflow),
      .o_underflow    (underflow)
   );

   typedef struct {
      logic          rst, fl, we, re;
      logic [DW-1:0] wd;
      logic [CW-1:0] cnt;
      logic          rv;
      logic [DW-1:0] rdd;
      logic [2:0]    flg;   // {wr_ready, almost_full, almost_empty}
      logic          ov, un;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, fl, we, input logic [DW-1:0] wd, input logic re,
                      input logic [CW-1:0] cnt, input logic rv, input logic [DW-1:0] rdd,
                      input logic [2:0] flg, input logic ov, un);
      vec_t v;
      v.rst = rst; v.fl = fl; v.we = we; v.wd = wd; v.re = re;
      v.cnt = cnt; v.rv = rv; v.rdd = rdd; v.flg = flg; v.ov = ov; v.un = un;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Drive on the falling edge, then sample 1 time unit after the rising edge.
   task automatic step(input logic rst, fl, we, input logic [DW-1:0] wd, input logic re);
      @(negedge clk);
      reset = rst; flush = fl; wr_en = we; wr_data = wd; rd_en = re;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] lvl(input int c);
      // Hand rule for the defaults: full at 8, almost-full from 7, almost-empty up to 1.
      return {c < 8, c >= 7, c <= 1};
   endfunction

   initial begin
      logic [DW-1:0] q[$];
      logic [DW-1:0] last;
      int            mcnt;
      logic [DW-1:0] drain_data [8];

      reset = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

      // ---- table: reset, basic write/read, fill, overflow, full r+w, drain, empty r+w
      add(1,0,0,8'h00,0, 0,0,8'h00, 3'b101, 0,0);
      add(0,0,1,8'h11,0, 1,0,8'h00, 3'b101, 0,0);
      add(0,0,1,8'h22,0, 2,0,8'h00, 3'b100, 0,0);
      add(0,0,1,8'h33,0, 3,0,8'h00, 3'b100, 0,0);
      add(0,0,0,8'h00,1, 2,1,8'h11, 3'b100, 0,0);
      add(0,0,0,8'h00,1, 1,1,8'h22, 3'b101, 0,0);
      add(0,0,0,8'h00,1, 0,1,8'h33, 3'b101, 0,0);
      add(0,0,0,8'h00,0, 0,0,8'h33, 3'b101, 0,0);
      for (int j = 0; j < 8; j++)
         add(0,0,1,DW'(j+1),0, CW'(j+1),0,8'h33, lvl(j+1), 0,0);
      add(0,0,1,8'h09,0, 8,0,8'h33, 3'b010, 1,0);
      add(0,0,1,8'hA5,1, 8,1,8'h01, 3'b010, 1,0);
      drain_data = '{8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'hA5};
      for (int j = 0; j < 8; j++)
         add(0,0,0,8'h00,1, CW'(7-j),1,drain_data[j], lvl(7-j), 1,0);
      add(0,0,1,8'h5A,1, 1,0,8'hA5, 3'b101, 1,1);
      add(0,0,0,8'h00,1, 0,1,8'h5A, 3'b101, 1,1);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].fl, vecs[i].we, vecs[i].wd, vecs[i].re);
         chk("count",        i, 32'(count),        32'(vecs[i].cnt));
         chk("rd_val",       i, 32'(rd_val),       32'(vecs[i].rv));
         chk("rd_data",      i, 32'(rd_data),      32'(vecs[i].rdd));
         chk("wr_ready",     i, 32'(wr_ready),     32'(vecs[i].flg[2]));
         chk("almost_full",  i, 32'(almost_full),  32'(vecs[i].flg[1]));
         chk("almost_empty", i, 32'(almost_empty), 32'(vecs[i].flg[0]));
         chk("overflow",     i, 32'(overflow),     32'(vecs[i].ov));
         chk("underflow",    i, 32'(underflow),    32'(vecs[i].un));
      end

      // ---- wrap both pointers past index 7 with interleaved reads
      mcnt = 0;
      last = 8'h5A;
      for (int i = 0; i < 20; i++) begin
         logic we, re, ra, wa;
         we = (i < 12);
         re = (i % 3 != 0) || (i >= 12);
         ra = re && (mcnt > 0);
         wa = we && (mcnt < DEPTH || ra);
         step(0, 0, we, DW'(8'hC0 + i), re);
         if (ra) last = q.pop_front();
         if (wa) q.push_back(DW'(8'hC0 + i));
         mcnt = mcnt + (wa ? 1 : 0) - (ra ? 1 : 0);
         chk("wrap_count",  100 + i, 32'(count),  32'(mcnt));
         chk("wrap_rd_val", 100 + i, 32'(rd_val), 32'(ra));
         chk("wrap_data",   100 + i, 32'(rd_data), 32'(last));
      end
      chk("wrap_empty", 120, 32'(count), 32'(0));

      // ---- flush with concurrent write at count 5
      for (int i = 0; i < 5; i++) step(0, 0, 1, DW'(8'hE0 + i), 0);
      chk("pre_flush_count", 200, 32'(count), 32'(5));
      step(0, 1, 1, 8'hFF, 1);
      chk("flush_count",     201, 32'(count),     32'(0));
      chk("flush_rd_val",    201, 32'(rd_val),    32'(0));
      chk("flush_rd_data",   201, 32'(rd_data),   32'(last));
      chk("flush_overflow",  201, 32'(overflow),  32'(1));
      chk("flush_underflow", 201, 32'(underflow), 32'(1));
      step(0, 0, 0, 8'h00, 0);
      chk("flush_dropped",   202, 32'(count),     32'(0));
      chk("flush_empty_flg", 202, 32'(almost_empty), 32'(1));

      // ---- reset clears sticky flags; a write during reset is dropped
      step(1, 0, 1, 8'h77, 0);
      chk("rst_overflow",  300, 32'(overflow),  32'(0));
      chk("rst_underflow", 300, 32'(underflow), 32'(0));
      chk("rst_count",     300, 32'(count),     32'(0));
      chk("rst_rd_data",   300, 32'(rd_data),   32'(0));
      chk("rst_wr_ready",  300, 32'(wr_ready),  32'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks %0d", checks);
      $fatal(1, "timeout");
   end

endmodule : tb_fifo_ring
